// File: rtl/iq_pkg.sv
// iq_pkg: shared constants and types for the issue queue slice.
//   PHYS_TAG_W    - default physical register tag width
//   IQ_PAYLOAD_W  - default opaque micro-op payload width
//   IQ_WAKE_PORTS - default number of wakeup broadcast ports
//   iq_entry_t    - entry layout for the default configuration
package iq_pkg;

  localparam int unsigned PHYS_TAG_W    = 6;
  localparam int unsigned IQ_PAYLOAD_W  = 32;
  localparam int unsigned IQ_WAKE_PORTS = 2;

  typedef struct packed {
    logic                    valid;
    logic                    src1_rdy;
    logic                    src2_rdy;
    logic [PHYS_TAG_W-1:0]   src1_tag;
    logic [PHYS_TAG_W-1:0]   src2_tag;
    logic [PHYS_TAG_W-1:0]   dst_tag;
    logic [IQ_PAYLOAD_W-1:0] payload;
  } iq_entry_t;

endpackage

// File: rtl/iq_slot.sv
// iq_slot: one issue-queue entry with its wakeup comparators.
//   clk, rst      - clock, synchronous active-high reset
//   flush_i       - drop the entry
//   we_i          - write a dispatched micro-op (wr_*_i fields)
//   issue_clr_i   - entry is moving to the issue register this edge
//   wake_valid_i  - per-port broadcast valid
//   wake_tag_i    - flattened broadcast tags, port p at [p*TAG_W +: TAG_W]
//   valid_o       - entry occupied
//   ready_o       - entry eligible for selection
//   dst_tag_o, payload_o - stored destination tag and payload
// Optional: ISSUE_QUEUE_WAKEUP_BYPASS_EN folds same-cycle wakeup hits into ready_o.
module iq_slot
  import iq_pkg::*;
#(
  parameter int unsigned TAG_W      = PHYS_TAG_W,
  parameter int unsigned PAYLOAD_W  = IQ_PAYLOAD_W,
  parameter int unsigned WAKE_PORTS = IQ_WAKE_PORTS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        we_i,
  input  logic                        issue_clr_i,
  input  logic [TAG_W-1:0]            wr_src1_tag_i,
  input  logic [TAG_W-1:0]            wr_src2_tag_i,
  input  logic                        wr_src1_rdy_i,
  input  logic                        wr_src2_rdy_i,
  input  logic [TAG_W-1:0]            wr_dst_tag_i,
  input  logic [PAYLOAD_W-1:0]        wr_payload_i,
  input  logic [WAKE_PORTS-1:0]       wake_valid_i,
  input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag_i,
  output logic                        valid_o,
  output logic                        ready_o,
  output logic [TAG_W-1:0]            dst_tag_o,
  output logic [PAYLOAD_W-1:0]        payload_o
);

  logic                 valid_q, src1_rdy_q, src2_rdy_q;
  logic [TAG_W-1:0]     src1_tag_q, src2_tag_q, dst_tag_q;
  logic [PAYLOAD_W-1:0] payload_q;

  // Hits against the stored tags and against the tags being written, so a
  // wakeup coinciding with dispatch is captured rather than lost.
  logic st_hit1, st_hit2, wr_hit1, wr_hit2;

  always_comb begin
    st_hit1 = 1'b0;
    st_hit2 = 1'b0;
    wr_hit1 = 1'b0;
    wr_hit2 = 1'b0;
    for (int unsigned p = 0; p < WAKE_PORTS; p++) begin
      if (wake_valid_i[p]) begin
        if (wake_tag_i[p*TAG_W +: TAG_W] == src1_tag_q)    st_hit1 = 1'b1;
        if (wake_tag_i[p*TAG_W +: TAG_W] == src2_tag_q)    st_hit2 = 1'b1;
        if (wake_tag_i[p*TAG_W +: TAG_W] == wr_src1_tag_i) wr_hit1 = 1'b1;
        if (wake_tag_i[p*TAG_W +: TAG_W] == wr_src2_tag_i) wr_hit2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      src1_rdy_q <= 1'b0;
      src2_rdy_q <= 1'b0;
      src1_tag_q <= '0;
      src2_tag_q <= '0;
      dst_tag_q  <= '0;
      payload_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (we_i) begin
      valid_q    <= 1'b1;
      src1_rdy_q <= wr_src1_rdy_i | wr_hit1;
      src2_rdy_q <= wr_src2_rdy_i | wr_hit2;
      src1_tag_q <= wr_src1_tag_i;
      src2_tag_q <= wr_src2_tag_i;
      dst_tag_q  <= wr_dst_tag_i;
      payload_q  <= wr_payload_i;
    end else begin
      if (issue_clr_i) valid_q    <= 1'b0;
      if (st_hit1)     src1_rdy_q <= 1'b1;
      if (st_hit2)     src2_rdy_q <= 1'b1;
    end
  end

`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
  assign ready_o = valid_q & (src1_rdy_q | st_hit1) & (src2_rdy_q | st_hit2);
`else
  assign ready_o = valid_q & src1_rdy_q & src2_rdy_q;
`endif

  assign valid_o   = valid_q;
  assign dst_tag_o = dst_tag_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/select_left_most.sv
// select_left_most: index of the lowest set bit of a request vector.
//   req_i - request mask
//   idx_o - index of lowest set bit; 0 when the mask is empty, so callers
//           must qualify with their own OR-reduction of the mask
module select_left_most #(
  parameter int unsigned N = 8,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o
);

  logic found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        idx_o = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// issue_queue: out-of-order issue queue between dispatch and execute.
//   clk, rst         - clock, synchronous active-high reset
//   flush            - clear all entries and the issue register valid
//   disp_*           - dispatch request (valid/ready, source tags/ready bits,
//                      destination tag, payload)
//   wake_valid/tag   - WAKE_PORTS tag broadcasts, port p at [p*TAG_W +: TAG_W]
//   iss_*            - registered issue output with valid/ready handshake
//   occupancy        - number of valid entries (issue register excluded)
// Optional: define ISSUE_QUEUE_WAKEUP_BYPASS_EN to let an entry woken this
// cycle be selected in the same cycle (wakeup-to-issue latency 1 instead of 2).
module issue_queue
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TAG_W      = PHYS_TAG_W,
  parameter int unsigned PAYLOAD_W  = IQ_PAYLOAD_W,
  parameter int unsigned WAKE_PORTS = IQ_WAKE_PORTS,
  parameter int unsigned IDX_W      = $clog2(DEPTH),
  parameter int unsigned OCC_W      = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [TAG_W-1:0]            disp_src1_tag,
  input  logic [TAG_W-1:0]            disp_src2_tag,
  input  logic                        disp_src1_rdy,
  input  logic                        disp_src2_rdy,
  input  logic [TAG_W-1:0]            disp_dst_tag,
  input  logic [PAYLOAD_W-1:0]        disp_payload,
  input  logic [WAKE_PORTS-1:0]       wake_valid,
  input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [TAG_W-1:0]            iss_dst_tag,
  output logic [PAYLOAD_W-1:0]        iss_payload,
  output logic [OCC_W-1:0]            occupancy
);

  logic [DEPTH-1:0]     valid_vec, ready_vec;
  logic [TAG_W-1:0]     slot_dst [DEPTH];
  logic [PAYLOAD_W-1:0] slot_pay [DEPTH];
  logic [IDX_W-1:0]     alloc_idx, sel_idx;
  logic                 any_ready, disp_fire, issue_load;

  logic                 iss_valid_q;
  logic [TAG_W-1:0]     iss_dst_q;
  logic [PAYLOAD_W-1:0] iss_pay_q;
  logic [OCC_W-1:0]     occ_q;

  assign disp_ready = (occ_q < OCC_W'(DEPTH));
  assign disp_fire  = disp_valid & disp_ready;
  assign any_ready  = |ready_vec;
  assign issue_load = any_ready & (~iss_valid_q | iss_ready);

  select_left_most #(.N(DEPTH), .W(IDX_W)) u_alloc_sel (
    .req_i (~valid_vec),
    .idx_o (alloc_idx)
  );

  select_left_most #(.N(DEPTH), .W(IDX_W)) u_issue_sel (
    .req_i (ready_vec),
    .idx_o (sel_idx)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    iq_slot #(
      .TAG_W      (TAG_W),
      .PAYLOAD_W  (PAYLOAD_W),
      .WAKE_PORTS (WAKE_PORTS)
    ) u_slot (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (flush),
      .we_i          (disp_fire && (alloc_idx == IDX_W'(i))),
      .issue_clr_i   (issue_load && (sel_idx == IDX_W'(i))),
      .wr_src1_tag_i (disp_src1_tag),
      .wr_src2_tag_i (disp_src2_tag),
      .wr_src1_rdy_i (disp_src1_rdy),
      .wr_src2_rdy_i (disp_src2_rdy),
      .wr_dst_tag_i  (disp_dst_tag),
      .wr_payload_i  (disp_payload),
      .wake_valid_i  (wake_valid),
      .wake_tag_i    (wake_tag),
      .valid_o       (valid_vec[i]),
      .ready_o       (ready_vec[i]),
      .dst_tag_o     (slot_dst[i]),
      .payload_o     (slot_pay[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid_q <= 1'b0;
      iss_dst_q   <= '0;
      iss_pay_q   <= '0;
    end else if (flush) begin
      iss_valid_q <= 1'b0;
    end else if (issue_load) begin
      iss_valid_q <= 1'b1;
      iss_dst_q   <= slot_dst[sel_idx];
      iss_pay_q   <= slot_pay[sel_idx];
    end else if (iss_ready) begin
      iss_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(disp_fire) - OCC_W'(issue_load);
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_dst_tag = iss_dst_q;
  assign iss_payload = iss_pay_q;
  assign occupancy   = occ_q;

endmodule
